// File: rtl/alu_multicycle.sv
// Execute-stage ALU: single-cycle logic/arith/compare ops, iterative one-bit-per-cycle shifts.
// Requests use a valid/ready handshake; done pulses for one cycle when ALUResult/Zero update.
module alu_multicycle #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            Operation,
    input  logic [DATA_WIDTH-1:0] SrcA,
    input  logic [DATA_WIDTH-1:0] SrcB,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] ALUResult,
    output logic                  Zero
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0011;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRL = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SRA = 4'b0111;
    localparam logic [3:0] OP_EQ  = 4'b1000;
    localparam logic [3:0] OP_SLT = 4'b1100;

    state_t                  state_q, state_d;
    logic [SHAMT_WIDTH-1:0]  count_q, count_d;
    logic [DATA_WIDTH-1:0]   work_q, work_d;
    logic [1:0]              kind_q, kind_d;
    logic [DATA_WIDTH-1:0]   result_q, result_d;
    logic                    zero_q, zero_d;
    logic                    done_q, done_d;

    function automatic logic is_shift(input logic [3:0] op);
        is_shift = (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] alu_single(input logic [3:0] op,
                                                         input logic [DATA_WIDTH-1:0] a,
                                                         input logic [DATA_WIDTH-1:0] b);
        logic signed [DATA_WIDTH-1:0] sa;
        logic signed [DATA_WIDTH-1:0] sb;
        sa = a;
        sb = b;
        case (op)
            OP_AND:  alu_single = a & b;
            OP_OR:   alu_single = a | b;
            OP_ADD:  alu_single = a + b;
            OP_XOR:  alu_single = a ^ b;
            OP_SUB:  alu_single = a - b;
            OP_EQ:   alu_single = {{(DATA_WIDTH-1){1'b0}}, (a == b)};
            OP_SLT:  alu_single = {{(DATA_WIDTH-1){1'b0}}, (sa < sb)};
            default: alu_single = '0;
        endcase
    endfunction

    // kind is Operation[1:0]: 00 SLL, 01 SRL, 11 SRA
    function automatic logic [DATA_WIDTH-1:0] shift_one(input logic [1:0] kind,
                                                        input logic [DATA_WIDTH-1:0] w);
        case (kind)
            2'b00:   shift_one = {w[DATA_WIDTH-2:0], 1'b0};
            2'b01:   shift_one = {1'b0, w[DATA_WIDTH-1:1]};
            default: shift_one = {w[DATA_WIDTH-1], w[DATA_WIDTH-1:1]};
        endcase
    endfunction

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        work_d   = work_q;
        kind_d   = kind_q;
        result_d = result_q;
        zero_d   = zero_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (is_shift(Operation)) begin
                        work_d  = SrcA;
                        count_d = SrcB[SHAMT_WIDTH-1:0];
                        kind_d  = Operation[1:0];
                        state_d = SHIFT;
                    end else begin
                        result_d = alu_single(Operation, SrcA, SrcB);
                        zero_d   = (result_d == '0);
                        done_d   = 1'b1;
                        state_d  = DONE;
                    end
                end
            end
            SHIFT: begin
                if (count_q != '0) begin
                    work_d  = shift_one(kind_q, work_q);
                    count_d = count_q - SHAMT_WIDTH'(1);
                end else begin
                    result_d = work_q;
                    zero_d   = (work_q == '0);
                    done_d   = 1'b1;
                    state_d  = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
        end
        // Working register and op kind are reloaded on every shift accept, so they need no reset
        work_q <= work_d;
        kind_q <= kind_d;
    end

    assign in_ready  = (state_q == IDLE);
    assign done      = done_q;
    assign ALUResult = result_q;
    assign Zero      = zero_q;

endmodule
